// File: rtl/calc_ctrl_p.sv
// Keypad-driven sign-magnitude calculator controller (add/sub/mul/negate).
// Define CALC_CHAIN_EN to let an operator after a result reuse that result.
module calc_ctrl_p #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         nRST,
   input  logic         key_valid,
   input  logic [3:0]   key_digit,
   input  logic         op_valid,
   input  logic [2:0]   op_code,
   input  logic         equal_input,
   input  logic         clear_input,
   output logic         key_read,
   output logic         busy,
   output logic         complete,
   output logic         overflow,
   output logic [W-1:0] display_output
);
   localparam int M  = W - 1;
   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {OP1, OP2, EXEC, DONE} state_t;
   typedef enum logic [1:0] {F_ADD, F_SUB, F_MUL} fn_t;

   state_t         state;
   fn_t            fn;
   fn_t            op_fn;
   logic [W-1:0]   op1, op2;
   logic [2*M-1:0] acc, mcand;
   logic [M-1:0]   mplier;
   logic [CW-1:0]  cnt;

   logic           is_dig, is_op, op_neg;
   logic           ev_clr, ev_eq, ev_op, ev_dig;
   logic [W-1:0]   cur, cur_neg, cur_dig;
   logic [M+3:0]   ext;
   logic           dig_ovf;
   logic           s2, add_sign, add_ovf, mul_ovf, mul_sign;
   logic [M:0]     add_mag;
   logic [W-1:0]   add_res, mul_res, chain_op1;

   always_comb begin
      is_dig = key_valid && (key_digit <= 4'd9);
      is_op  = op_valid && (op_code >= 3'd1) && (op_code <= 3'd4);
      op_neg = (op_code == 3'd1);
      ev_clr = clear_input;
      ev_eq  = !ev_clr && equal_input && (state == OP2);
      // negate has no operand to act on once a result is shown
      ev_op  = !ev_clr && !ev_eq && is_op && (state != EXEC)
               && !(op_neg && state == DONE);
      ev_dig = !ev_clr && !ev_eq && !ev_op && is_dig
               && (state != EXEC);

      case (op_code)
         3'd3:    op_fn = F_SUB;
         3'd4:    op_fn = F_MUL;
         default: op_fn = F_ADD;
      endcase

      cur     = (state == OP2) ? op2 : op1;
      cur_neg = (cur[M-1:0] == '0) ? '0
                : {~cur[W-1], cur[M-1:0]};
      ext     = ({4'd0, cur[M-1:0]} << 3)
              + ({4'd0, cur[M-1:0]} << 1)
              + (M+4)'(key_digit);
      dig_ovf = ext > {4'd0, {M{1'b1}}};
      cur_dig = {cur[W-1], ext[M-1:0]};

      s2 = op2[W-1] ^ (fn == F_SUB);
      if (op1[W-1] == s2) begin
         add_mag  = {1'b0, op1[M-1:0]} + {1'b0, op2[M-1:0]};
         add_sign = s2;
      end else if (op1[M-1:0] >= op2[M-1:0]) begin
         add_mag  = {1'b0, op1[M-1:0]} - {1'b0, op2[M-1:0]};
         add_sign = op1[W-1];
      end else begin
         add_mag  = {1'b0, op2[M-1:0]} - {1'b0, op1[M-1:0]};
         add_sign = s2;
      end
      add_ovf = add_mag[M];
      add_res = add_ovf ? {add_sign, {M{1'b1}}}
              : (add_mag == '0) ? '0
              : {add_sign, add_mag[M-1:0]};

      mul_sign = op1[W-1] ^ op2[W-1];
      mul_ovf  = |acc[2*M-1:M];
      mul_res  = mul_ovf ? {mul_sign, {M{1'b1}}}
               : (acc == '0) ? '0
               : {mul_sign, acc[M-1:0]};

`ifdef CALC_CHAIN_EN
      chain_op1 = display_output;
`else
      chain_op1 = '0;
`endif
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state          <= OP1;
         fn             <= F_ADD;
         op1            <= '0;
         op2            <= '0;
         acc            <= '0;
         mcand          <= '0;
         mplier         <= '0;
         cnt            <= '0;
         key_read       <= 1'b0;
         busy           <= 1'b0;
         complete       <= 1'b0;
         overflow       <= 1'b0;
         display_output <= '0;
      end else begin
         key_read <= ev_clr | ev_eq | ev_op | ev_dig;
         unique case (1'b1)
            ev_clr: begin
               state          <= OP1;
               fn             <= F_ADD;
               op1            <= '0;
               op2            <= '0;
               acc            <= '0;
               mcand          <= '0;
               mplier         <= '0;
               cnt            <= '0;
               busy           <= 1'b0;
               complete       <= 1'b0;
               overflow       <= 1'b0;
               display_output <= '0;
            end
            ev_eq: begin
               state  <= EXEC;
               busy   <= 1'b1;
               acc    <= '0;
               mcand  <= (2*M)'(op1[M-1:0]);
               mplier <= op2[M-1:0];
               cnt    <= '0;
            end
            ev_op: begin
               if (op_neg) begin
                  if (state == OP2) op2 <= cur_neg;
                  else              op1 <= cur_neg;
                  display_output <= cur_neg;
               end else begin
                  fn <= op_fn;
                  if (state != OP2) begin
                     state          <= OP2;
                     op2            <= '0;
                     display_output <= '0;
                  end
                  if (state == DONE) begin
                     op1      <= chain_op1;
                     complete <= 1'b0;
                     overflow <= 1'b0;
                  end
               end
            end
            ev_dig: begin
               if (state == DONE) begin
                  state          <= OP1;
                  op1            <= {{(W-4){1'b0}}, key_digit};
                  op2            <= '0;
                  display_output <= {{(W-4){1'b0}}, key_digit};
                  complete       <= 1'b0;
                  overflow       <= 1'b0;
               end else if (dig_ovf) begin
                  overflow <= 1'b1;
               end else begin
                  if (state == OP2) op2 <= cur_dig;
                  else              op1 <= cur_dig;
                  display_output <= cur_dig;
               end
            end
            default: begin
               if (state == EXEC) begin
                  if (fn != F_MUL) begin
                     state          <= DONE;
                     busy           <= 1'b0;
                     complete       <= 1'b1;
                     overflow       <= add_ovf;
                     display_output <= add_res;
                  end else if (cnt == CW'(M)) begin
                     state          <= DONE;
                     busy           <= 1'b0;
                     complete       <= 1'b1;
                     overflow       <= mul_ovf;
                     display_output <= mul_res;
                  end else begin
                     if (mplier[0]) acc <= acc + mcand;
                     mcand  <= mcand << 1;
                     mplier <= mplier >> 1;
                     cnt    <= cnt + 1'b1;
                  end
               end
            end
         endcase
      end
   end
endmodule
